pipe_stage_reg: RTL and testbench

Parametrised valid/ready pipeline stage register, the generic successor of the per-stage boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque DATA_W-bit payload and supports a stage-local completion qualifier (ready_go) and a synchronous pipeline flush. It also provides an optional two-entry skid buffer that removes the combinational ready path, and a saturating back-pressure counter for performance analysis.

---
 rtl/pipe_pkg.sv | 44 ++++
 rtl/pipe_stall_cnt.sv | 36 +++
 rtl/pipe_stage_reg.sv | 116 +++++++++++
 tb/tb_pipe_stage_reg.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths and per-stage payload bundles for the pipeline boundary registers.
// Stage wrappers size pipe_stage_reg with the *_W localparams below.
package pipe_pkg;

  localparam int PIPE_DATA_W_DEF = 32;
  localparam int PIPE_CNT_W_DEF  = 16;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int CTL_W = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rd;
    logic [CTL_W-1:0] ctrl;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0]  alu_res;
    logic [XLEN-1:0]  store_val;
    logic [REG_W-1:0] rd;
    logic [CTL_W-1:0] ctrl;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0]  wb_val;
    logic [REG_W-1:0] rd;
    logic             wb_en;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_stall_cnt.sv
// Saturating event counter with synchronous clear; clear wins over increment.
// Shared by the stage registers and other performance monitors.
module pipe_stall_cnt
  import pipe_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with ready_go, flush and stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with registered o_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W_DEF,
  parameter int CNT_W  = PIPE_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready_go,
  input  logic              i_flush,
  input  logic              i_cnt_clr,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              up_xfer;
  logic              dn_xfer;
  logic              stall;

  assign o_valid = main_valid_q & i_ready_go;
  assign o_data  = main_data_q;
  assign dn_xfer = o_valid & i_ready;
  assign up_xfer = i_valid & o_ready;
  assign stall   = o_valid & ~i_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  assign o_ready = ~skid_valid_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      // o_ready is low here, so only the skid-to-main move can happen
      if (dn_xfer) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (up_xfer) begin
      if (!main_valid_q || dn_xfer) begin
        main_data_d  = i_data;
        main_valid_d = 1'b1;
      end else begin
        skid_data_d  = i_data;
        skid_valid_d = 1'b1;
      end
    end else if (dn_xfer) begin
      main_valid_d = 1'b0;
    end
    if (i_flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign o_ready = ~main_valid_q | (i_ready & i_ready_go);

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    if (up_xfer) begin
      main_data_d  = i_data;
      main_valid_d = 1'b1;
    end else if (dn_xfer) begin
      main_valid_d = 1'b0;
    end
    if (i_flush) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
    end
  end

  pipe_stall_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk),
    .rst_ni(rst),
    .inc_i (stall),
    .clr_i (i_cnt_clr),
    .cnt_o (o_stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: stimulus queues expected payloads,
// a negedge monitor pops and compares every downstream transfer.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          i_ready_go;
  logic          i_flush;
  logic          i_cnt_clr;
  logic [CW-1:0] o_stall_cnt;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] sbq[$];
  logic [DW-1:0] exp_d;

  pipe_stage_reg #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .i_ready_go (i_ready_go),
    .i_flush    (i_flush),
    .i_cnt_clr  (i_cnt_clr),
    .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [DW-1:0] a,
                     input logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit exp);
    i_valid = 1'b1;
    i_data  = d;
    if (exp) sbq.push_back(d);
  endtask

  always @(negedge clk) begin
    if (rst && o_valid && i_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected: got %h expected none", o_data);
      end else begin
        exp_d = sbq.pop_front();
        if (o_data !== exp_d) begin
          errors++;
          $display("FAIL mon_data: got %h expected %h", o_data, exp_d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    i_valid = 1'b0;
    i_data = '0;
    i_ready = 1'b0;
    i_ready_go = 1'b1;
    i_flush = 1'b0;
    i_cnt_clr = 1'b0;
    #2;
    chk("rst_valid", DW'(o_valid), 0);
    chk("rst_ready", DW'(o_ready), 1);
    chk("rst_data", o_data, 0);
    chk("rst_cnt", DW'(o_stall_cnt), 0);
    tick();
    rst = 1'b1;

    // reset mid-operation
    send(32'hA5A5A5A5, 1'b0);
    tick();
    i_valid = 1'b0;
    chk("fill_a5", o_data, 32'hA5A5A5A5);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", DW'(o_valid), 0);
    chk("mid_rst_ready", DW'(o_ready), 1);
    chk("mid_rst_data", o_data, 0);
    tick();
    rst = 1'b1;
    i_ready = 1'b1;
    send(32'h5A, 1'b1);
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    chk("first_acc_valid", DW'(o_valid), 1);
    tick();

    // streaming
    for (int k = 1; k <= 8; k++) begin
      send(DW'(k), 1'b1);
      tick();
      @(negedge clk);
      chk("stream_valid", DW'(o_valid), 1);
      chk("stream_data", o_data, DW'(k));
    end
    i_valid = 1'b0;
    tick();
    tick();
    chk("stream_cnt", DW'(o_stall_cnt), 0);

    // back-pressure
    i_ready = 1'b0;
    send(32'h11, 1'b1);
    tick();
`ifdef PIPE_STAGE_SKID_EN
    send(32'h22, 1'b1);
`else
    i_valid = 1'b0;
`endif
    for (int k = 0; k < 5; k++) begin
      tick();
      i_valid = 1'b0;
    end
    @(negedge clk);
    chk("bp_cnt", DW'(o_stall_cnt), 5);
    chk("bp_data", o_data, 32'h11);
    chk("bp_valid", DW'(o_valid), 1);
    chk("bp_ready", DW'(o_ready), 0);
    tick();
    i_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("bp_cnt_after", DW'(o_stall_cnt), 6);
    i_cnt_clr = 1'b1;
    tick();
    i_cnt_clr = 1'b0;
    chk("clr_cnt", DW'(o_stall_cnt), 0);

    // ready_go low
    i_ready_go = 1'b0;
    send(32'h33, 1'b1);
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rg_valid_low", DW'(o_valid), 0);
`ifdef PIPE_STAGE_SKID_EN
      chk("rg_ready", DW'(o_ready), 1);
`else
      chk("rg_ready", DW'(o_ready), 0);
`endif
      tick();
    end
    i_ready_go = 1'b1;
    @(negedge clk);
    chk("rg_valid_hi", DW'(o_valid), 1);
    chk("rg_data", o_data, 32'h33);
    tick();
    chk("rg_cnt", DW'(o_stall_cnt), 0);

    // flush while full
    i_ready = 1'b0;
    send(32'h55, 1'b0);
    tick();
`ifdef PIPE_STAGE_SKID_EN
    send(32'h66, 1'b0);
    tick();
`endif
    @(negedge clk);
    chk("full_ready", DW'(o_ready), 0);
    send(32'h44, 1'b0);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", DW'(o_valid), 0);
    chk("flush_ready", DW'(o_ready), 1);
    i_ready = 1'b1;
    tick();
    tick();
    tick();

    // counter saturation and clear
    i_cnt_clr = 1'b1;
    tick();
    i_cnt_clr = 1'b0;
    i_ready = 1'b0;
    send(32'h77, 1'b1);
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("sat_7", DW'(o_stall_cnt), 7);
    for (int k = 0; k < 3; k++) tick();
    chk("sat_hold", DW'(o_stall_cnt), 7);
    i_cnt_clr = 1'b1;
    tick();
    i_cnt_clr = 1'b0;
    chk("sat_clr", DW'(o_stall_cnt), 0);
    tick();
    chk("sat_resume", DW'(o_stall_cnt), 1);
    i_ready = 1'b1;
    tick();
    tick();

    chk("sb_empty", DW'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
